spi_req_scheduler: RTL and testbench
====================================

# spi_req_scheduler

Round-robin scheduler sharing one registered SPI master among NREQ requesters. Accepts one transfer request per requester (its own mode/speed/word length/timing and MOSI word), then drives the master's start and config inputs. It tracks the busy handshake and returns the captured MISO word to the originating requester. Sits between the bus-side register bank and the SPI master register wrapper; also drives the slave-select index for the external CS demux.

## Interface
- NREQ, 4: number of requesters, 2..8
- START_TO, 15: max cycles from start pulse to busy rise before the transfer is aborted with an error
- GCLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- req_valid_i  in  NREQ  per-requester request
- req_ready_o  out  NREQ  one-hot accept pulse
- req_cfg_i  in  30*NREQ  per requester, LSB first: spi_mode[1:0], sck_speed[3:2], word_len[5:4], IFG[13:6], CS_SCK[21:14], SCK_CS[29:22]
- req_mosi_i  in  32*NREQ  per-requester MOSI word
- rsp_valid_o  out  NREQ  one-hot, 1-cycle response pulse
- rsp_data_o  out  32  MISO word, valid with rsp_valid_o
- rsp_err_o  out  1  start timeout, valid with rsp_valid_o
- start_o  out  1  start pulse to the SPI master wrapper
- busy_i  in  1  master busy, unregistered
- spi_mode_o, sck_speed_o, word_len_o  out  2 each  latched config
- IFG_o, CS_SCK_o, SCK_CS_o  out  8 each  latched timing
- mosi_data_o  out  32  latched MOSI word
- miso_data_i  in  32  registered MISO word from the wrapper
- sel_o  out  clog2(NREQ)  index of the granted requester; drives the CS demux

## Operation
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, SETTLE, RESP.
- IDLE: if any req_valid_i is high, grant by round-robin starting from (last_grant+1) mod NREQ. Pulse req_ready_o[g]. Latch cfg, mosi and sel_o = g. Go to LOAD.
- LOAD: config outputs are stable; hold one cycle to cover the wrapper's input register stage. Go to START.
- START: start_o=1 for exactly one cycle; clear timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: if busy_i=1, go to WAIT_DONE. Otherwise increment the counter; at count==START_TO set err and go to RESP.
- WAIT_DONE: stay while busy_i=1; on busy_i=0 go to SETTLE.
- SETTLE: wait 2 cycles (miso register latency), capture miso_data_i, go to RESP.
- RESP: rsp_valid_o[g]=1 for one cycle with rsp_data_o and rsp_err_o; last_grant=g; go to IDLE.
- Config, mosi and sel_o outputs hold from LOAD until the next grant; they never change while busy.
- A requester dropping req_valid_i after its grant has no effect; it still receives its response.
- On error, rsp_data_o=0.

## Timing
- Reset values: FSM IDLE, last_grant=NREQ-1 (so requester 0 wins first), all outputs 0, sel_o=0.
- RST mid-transfer returns the FSM to IDLE next cycle. No response is issued. Outputs go to reset values, including start_o=0.
- Grant latency: req_valid_i rise in IDLE gives req_ready_o next cycle. start_o follows 2 cycles after req_ready_o.
- Response: rsp_valid_o is 3 cycles after the busy_i fall (SETTLE 2 + RESP).
- Timeout response: START_TO+1 cycles after the start_o pulse.
- Requests arriving in non-IDLE states wait; at most one transfer is in flight.
- Simultaneous requests are ordered strictly by rotating priority; no starvation. Worst-case wait is NREQ-1 transfers.
- busy_i already high in START is treated as busy seen on the first WAIT_BUSY cycle.

## Structure
- Package spi_sched_pkg holds:
  - the state enum;
  - config field offsets/widths (CFG_W=30, MODE_LSB=0, SPEED_LSB=2, WLEN_LSB=4, IFG_LSB=6, CSSCK_LSB=14, SCKCS_LSB=22);
  - SETTLE_CYC=2 and LOAD_CYC=1 constants.
- Sub-module rr_arbiter: NREQ-wide request vector plus last_grant in, one-hot grant and index out; purely combinational.

## Test plan
- Single request: req 0 with cfg mode=1, speed=2, wlen=3, IFG=4, CS_SCK=2, SCK_CS=2 and mosi 0xA5A5_1234, slave model loops MOSI to MISO.
  - Required: ready[0] pulse; start_o 2 cycles later; outputs stable through busy.
  - Required: rsp_valid_o[0] with data 0xA5A5_1234 and err=0.
- All four requesters assert together: grants in order 0,1,2,3. A second simultaneous round starts at 0, since last_grant=3.
- Fairness: req 1 held continuously while req 2 pulses. Grants must alternate 1,2,1 and never take 1 twice while 2 is waiting.
- Timeout: busy_i tied 0. rsp_valid_o must come 16 cycles after start_o with err=1 and data=0.
- Reset during WAIT_DONE:
  - Required: no rsp_valid_o; all outputs 0 next cycle.
  - Required: the next request is granted to requester 0.
- Late request: req 3 asserted during WAIT_DONE of req 0 is granted the cycle after RESP.

Source files
------------

// File: rtl/spi_req_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sched_pkg
// Brief    : Shared types and config-field layout for spi_req_scheduler.
// Revision : 1.0
// ============================================================================
package spi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        SETTLE    = 3'd5,
        RESP      = 3'd6
    } state_t;

    localparam int DATA_W    = 32;
    localparam int CFG_W     = 30;
    localparam int MODE_LSB  = 0;
    localparam int SPEED_LSB = 2;
    localparam int WLEN_LSB  = 4;
    localparam int IFG_LSB   = 6;
    localparam int CSSCK_LSB = 14;
    localparam int SCKCS_LSB = 22;
    localparam int MODE_W    = 2;
    localparam int SPEED_W   = 2;
    localparam int WLEN_W    = 2;
    localparam int TIM_W     = 8;

    localparam int SETTLE_CYC = 2;
    localparam int LOAD_CYC   = 1;

endpackage
`default_nettype wire

// File: rtl/spi_req_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_req_scheduler_if
// Brief    : Requester-side and SPI-master-side signals of the scheduler.
// Revision : 1.0
// ============================================================================
interface spi_req_scheduler_if #(
    parameter int NREQ = 4
);
    import spi_sched_pkg::*;

    localparam int SEL_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [CFG_W*NREQ-1:0]  req_cfg_i;
    logic [DATA_W*NREQ-1:0] req_mosi_i;
    logic [NREQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]      rsp_data_o;
    logic                   rsp_err_o;

    logic                   start_o;
    logic                   busy_i;
    logic [MODE_W-1:0]      spi_mode_o;
    logic [SPEED_W-1:0]     sck_speed_o;
    logic [WLEN_W-1:0]      word_len_o;
    logic [TIM_W-1:0]       IFG_o;
    logic [TIM_W-1:0]       CS_SCK_o;
    logic [TIM_W-1:0]       SCK_CS_o;
    logic [DATA_W-1:0]      mosi_data_o;
    logic [DATA_W-1:0]      miso_data_i;
    logic [SEL_W-1:0]       sel_o;

    modport master (
        input  req_valid_i, req_cfg_i, req_mosi_i, busy_i, miso_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, start_o,
               spi_mode_o, sck_speed_o, word_len_o, IFG_o, CS_SCK_o, SCK_CS_o,
               mosi_data_o, sel_o
    );

    modport slave (
        output req_valid_i, req_cfg_i, req_mosi_i, busy_i, miso_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, start_o,
               spi_mode_o, sck_speed_o, word_len_o, IFG_o, CS_SCK_o, SCK_CS_o,
               mosi_data_o, sel_o
    );

endinterface
`default_nettype wire

// File: rtl/spi_req_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; priority starts after last_grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Distance 0 is the requester right after the last grant, NREQ-1 is the last one.
    function automatic int rr_dist(input int cand, input int last);
        return (cand - last - 1 + 2 * NREQ) % NREQ;
    endfunction

    int best_dist;

    always_comb begin
        best_dist = NREQ;
        idx_o     = '0;
        any_o     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && (rr_dist(i, int'(last_grant_i)) < best_dist)) begin
                best_dist = rr_dist(i, int'(last_grant_i));
                idx_o     = IDX_W'(i);
                any_o     = 1'b1;
            end
        end
        grant_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spi_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_req_scheduler
// Brief    : Round-robin sharing of one SPI master among NREQ requesters.
// Revision : 1.0
// ============================================================================
module spi_req_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int START_TO = 15
) (
    input  logic                GCLK,
    input  logic                RST,
    spi_req_scheduler_if.master bus
);

    localparam int SEL_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(START_TO + 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    last_grant_q, last_grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [DATA_W-1:0]   mosi_q, mosi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     req_ready_q, req_ready_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                start_q, start_d;

    logic [NREQ-1:0]     arb_grant;
    logic [SEL_W-1:0]    arb_idx;
    logic                arb_any;
    logic [CFG_W-1:0]    cfg_sel;
    logic [DATA_W-1:0]   mosi_sel;
    logic [NREQ-1:0]     sel_onehot;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (SEL_W)
    ) u_arb (
        .req_i        (bus.req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .idx_o        (arb_idx),
        .any_o        (arb_any)
    );

    always_comb begin
        cfg_sel  = '0;
        mosi_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                cfg_sel  = bus.req_cfg_i[i*CFG_W +: CFG_W];
                mosi_sel = bus.req_mosi_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_onehot = NREQ'(1) << sel_q;

    // Pulse outputs default low; latched config/sel hold until the next grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        cfg_d        = cfg_q;
        mosi_d       = mosi_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        start_d      = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_grant;
                    sel_d       = arb_idx;
                    cfg_d       = cfg_sel;
                    mosi_d      = mosi_sel;
                    cnt_d       = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(LOAD_CYC - 1)) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TO)) begin
                    rsp_valid_d = sel_onehot;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.busy_i) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // The wrapper registers MISO, so the word is only valid after the settle window.
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    rsp_valid_d = sel_onehot;
                    rsp_data_d  = bus.miso_data_i;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_grant_d = sel_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_W'(NREQ - 1);
            sel_q        <= '0;
            cfg_q        <= '0;
            mosi_q       <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            cfg_q        <= cfg_d;
            mosi_q       <= mosi_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            start_q      <= start_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.start_o     = start_q;
    assign bus.spi_mode_o  = cfg_q[MODE_LSB  +: MODE_W];
    assign bus.sck_speed_o = cfg_q[SPEED_LSB +: SPEED_W];
    assign bus.word_len_o  = cfg_q[WLEN_LSB  +: WLEN_W];
    assign bus.IFG_o       = cfg_q[IFG_LSB   +: TIM_W];
    assign bus.CS_SCK_o    = cfg_q[CSSCK_LSB +: TIM_W];
    assign bus.SCK_CS_o    = cfg_q[SCKCS_LSB +: TIM_W];
    assign bus.mosi_data_o = mosi_q;
    assign bus.sel_o       = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_req_scheduler
// Brief    : Scoreboard bench for spi_req_scheduler with a loopback SPI slave.
// Revision : 1.0
// ============================================================================
module tb_spi_req_scheduler;
    import spi_sched_pkg::*;

    localparam int NREQ     = 4;
    localparam int START_TO = 15;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic GCLK = 1'b0;
    logic RST  = 1'b1;
    int   cyc  = 0;

    spi_req_scheduler_if #(.NREQ(NREQ)) bus ();

    spi_req_scheduler #(
        .NREQ     (NREQ),
        .START_TO (START_TO)
    ) dut (
        .GCLK (GCLK),
        .RST  (RST),
        .bus  (bus.master)
    );

    always #5 GCLK = ~GCLK;
    always @(posedge GCLK) cyc <= cyc + 1;

    int          grant_q[$];
    rsp_t        rsp_q[$];
    logic [29:0] cfg_tab  [NREQ];
    logic [31:0] mosi_tab [NREQ];
    logic [NREQ-1:0] hold = '0;
    int  n_checks = 0;
    int  n_err    = 0;
    bit  busy_tie0 = 1'b0;
    bit  skip_hold = 1'b0;
    int  busy_len  = 3;
    int  cur_exp = 0, ready_cyc = 0, start_cyc = 0, fall_cyc = 0, last_rsp_cyc = 0;
    bit  prev_busy = 1'b0;
    rsp_t mon_e;
    int   mon_g;

    function automatic logic [29:0] mk_cfg(input int mode, input int speed, input int wlen,
                                           input int ifg, input int cssck, input int sckcs);
        logic [29:0] c;
        c = {8'(sckcs), 8'(cssck), 8'(ifg), 2'(wlen), 2'(speed), 2'(mode)};
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] cfg_out();
        return {bus.SCK_CS_o, bus.CS_SCK_o, bus.IFG_o, bus.word_len_o, bus.sck_speed_o, bus.spi_mode_o};
    endfunction

    task automatic step();
        @(negedge GCLK);
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ready_o[i] && !hold[i]) bus.req_valid_i[i] = 1'b0;
    endtask

    task automatic load_tabs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_cfg_i[i*30 +: 30]  = cfg_tab[i];
            bus.req_mosi_i[i*32 +: 32] = mosi_tab[i];
        end
    endtask

    task automatic expect_xfer(input int i, input bit timeout);
        rsp_t e;
        e.idx  = i;
        e.data = timeout ? 32'h0 : mosi_tab[i];
        e.err  = timeout;
        grant_q.push_back(i);
        rsp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.start_o,
                             bus.sel_o, cfg_out()}, 64'h0);
        chk({name, "_data"}, {bus.rsp_data_o, bus.mosi_data_o}, 64'h0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((grant_q.size() != 0 || rsp_q.size() != 0 || bus.busy_i) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_done_in_time"}, 64'(n < budget), 64'h1);
        repeat (3) step();
    endtask

    // Loopback slave: busy rises the cycle after start, MISO returns the MOSI word at busy fall.
    initial begin
        logic [31:0] cap;
        bus.busy_i      = 1'b0;
        bus.miso_data_i = '0;
        forever begin
            @(negedge GCLK);
            if (bus.start_o && !busy_tie0) begin
                cap = bus.mosi_data_o;
                @(posedge GCLK);
                #1 bus.busy_i = 1'b1;
                repeat (busy_len) @(posedge GCLK);
                #1;
                bus.busy_i      = 1'b0;
                bus.miso_data_i = cap;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT grants or responds.
    initial begin
        forever begin
            @(negedge GCLK);
            if (!RST) begin
                if (bus.req_ready_o != '0) begin
                    if (grant_q.size() == 0) begin
                        chk("unexpected_grant", 64'(bus.req_ready_o), 64'h0);
                    end else begin
                        mon_g   = grant_q.pop_front();
                        cur_exp = mon_g;
                        chk("grant_onehot", 64'(bus.req_ready_o), 64'(1) << mon_g);
                        chk("grant_sel_cfg_mosi", {bus.sel_o, cfg_out(), bus.mosi_data_o},
                            {2'(mon_g), cfg_tab[mon_g], mosi_tab[mon_g]});
                    end
                    ready_cyc = cyc;
                end
                if (bus.start_o) begin
                    chk("start_latency", 64'(cyc - ready_cyc), 64'd2);
                    start_cyc = cyc;
                end
                if (bus.busy_i && !skip_hold)
                    chk("hold_while_busy", {bus.sel_o, cfg_out(), bus.mosi_data_o},
                        {2'(cur_exp), cfg_tab[cur_exp], mosi_tab[cur_exp]});
                if (!bus.busy_i && prev_busy) fall_cyc = cyc;
                if (bus.rsp_valid_o != '0) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'h0);
                    end else begin
                        mon_e = rsp_q.pop_front();
                        chk("rsp_onehot", 64'(bus.rsp_valid_o), 64'(1) << mon_e.idx);
                        chk("rsp_data", 64'(bus.rsp_data_o), 64'(mon_e.data));
                        chk("rsp_err", 64'(bus.rsp_err_o), 64'(mon_e.err));
                        if (mon_e.err)
                            chk("timeout_latency", 64'(cyc - start_cyc), 64'(START_TO + 1));
                        else
                            chk("rsp_latency", 64'(cyc - fall_cyc), 64'd3);
                    end
                    last_rsp_cyc = cyc;
                end
            end
            prev_busy = bus.busy_i;
        end
    end

    initial begin
        int n;
        bus.req_valid_i = '0;
        bus.req_cfg_i   = '0;
        bus.req_mosi_i  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cfg_tab[i]  = mk_cfg(i, 3 - i, i, 10 + i, 20 + i, 30 + i);
            mosi_tab[i] = 32'h1111_0000 + 32'(i);
        end
        cfg_tab[0]  = mk_cfg(1, 2, 3, 4, 2, 2);
        mosi_tab[0] = 32'hA5A5_1234;
        load_tabs();
        repeat (3) step();
        check_zero("reset");
        RST = 1'b0;
        step();

        // Single request from requester 0
        expect_xfer(0, 1'b0);
        bus.req_valid_i[0] = 1'b1;
        drain("single", 100);

        // Fresh reset so the first simultaneous round starts at requester 0
        RST = 1'b1;
        step();
        step();
        check_zero("reset2");
        RST = 1'b0;
        step();
        for (int i = 0; i < NREQ; i++) mosi_tab[i] = 32'h1111_0000 + 32'(i);
        load_tabs();
        for (int i = 0; i < NREQ; i++) expect_xfer(i, 1'b0);
        bus.req_valid_i = '1;
        drain("round1", 300);

        for (int i = 0; i < NREQ; i++) mosi_tab[i] = 32'h2222_0000 + 32'(i * 7);
        load_tabs();
        for (int i = 0; i < NREQ; i++) expect_xfer(i, 1'b0);
        bus.req_valid_i = '1;
        drain("round2", 300);

        // Fairness: 1 held continuously, 2 pulsed once -> 1,2,1
        mosi_tab[1] = 32'hCAFE_0001;
        mosi_tab[2] = 32'hBEEF_0002;
        load_tabs();
        expect_xfer(1, 1'b0);
        expect_xfer(2, 1'b0);
        expect_xfer(1, 1'b0);
        hold[1] = 1'b1;
        bus.req_valid_i[1] = 1'b1;
        bus.req_valid_i[2] = 1'b1;
        n = 0;
        for (int k = 0; k < 300 && n < 2; k++) begin
            step();
            if (bus.req_ready_o[1]) n++;
        end
        chk("fair_second_grant_of_1", 64'(n), 64'd2);
        hold[1] = 1'b0;
        bus.req_valid_i[1] = 1'b0;
        drain("fairness", 200);

        // Start timeout: the slave never raises busy
        busy_tie0   = 1'b1;
        mosi_tab[2] = 32'h0BAD_F00D;
        load_tabs();
        expect_xfer(2, 1'b1);
        bus.req_valid_i[2] = 1'b1;
        drain("timeout", 100);
        busy_tie0 = 1'b0;

        // Reset during WAIT_DONE: grant is seen, no response follows
        skip_hold = 1'b1;
        busy_len  = 10;
        grant_q.push_back(1);
        bus.req_valid_i[1] = 1'b1;
        n = 0;
        while (!bus.busy_i && n < 50) begin
            step();
            n++;
        end
        chk("rst_test_busy_seen", 64'(n < 50), 64'h1);
        step();
        step();
        RST = 1'b1;
        step();
        check_zero("mid_xfer_reset");
        RST = 1'b0;
        n = 0;
        while (bus.busy_i && n < 50) begin
            step();
            n++;
        end
        repeat (6) step();
        skip_hold = 1'b0;
        busy_len  = 3;
        // 3 would win here if last_grant had not been reset
        expect_xfer(0, 1'b0);
        expect_xfer(3, 1'b0);
        bus.req_valid_i[0] = 1'b1;
        bus.req_valid_i[3] = 1'b1;
        drain("after_reset", 200);

        // Late request: 3 arrives while 0 is busy
        mosi_tab[0] = 32'h0000_5A5A;
        mosi_tab[3] = 32'h3333_C3C3;
        load_tabs();
        expect_xfer(0, 1'b0);
        expect_xfer(3, 1'b0);
        bus.req_valid_i[0] = 1'b1;
        n = 0;
        while (!bus.busy_i && n < 50) begin
            step();
            n++;
        end
        bus.req_valid_i[3] = 1'b1;
        n = 0;
        while (!bus.req_ready_o[3] && n < 100) begin
            step();
            n++;
        end
        chk("late_grant_seen", 64'(n < 100), 64'h1);
        chk("late_grant_after_resp", 64'(cyc - last_rsp_cyc), 64'd2);
        drain("late", 200);

        chk("scoreboard_empty", 64'(grant_q.size() + rsp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
